// File: rtl/fetch_pkg.sv
// Shared types and constants for the next-PC / instruction-fetch controller.
package fetch_pkg;

    localparam int XLEN    = 64;
    localparam int PC_STEP = 4;
    // Instruction storage width in the fetch buffer; INSTR_W of the top must not exceed it.
    localparam int ILEN    = 32;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DROP
    } fetch_state_e;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of PC-tagged instructions sitting between fetch and decode.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  fetch_entry_t     entry_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output fetch_entry_t     head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_o == CNT_W'(DEPTH));
    assign empty_o = (count_o == '0);
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem[rd_ptr];

    // Pointers rely on DEPTH being a power of two so they wrap naturally.
    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count_o <= count_o + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !reset_i) begin
            mem[wr_ptr] <= entry_i;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Next-PC and instruction-fetch controller: drives the PC register, the imem handshake and the decode buffer.
// Optional saturating perf counters are built when FETCH_PERF_EN is defined.
//
// state | meaning
// IDLE  | no request; waiting for buffer space
// REQ   | request presented at pc_i, held until granted
// WAIT  | granted, waiting for the response to buffer it
// DROP  | granted request squashed by a redirect, discard its response
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int INSTR_W    = 32
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [XLEN-1:0]    pc_i,
    output logic [XLEN-1:0]    pc_next_o,
    output logic               pc_ready_o,
    output logic               imem_req_o,
    output logic [XLEN-1:0]    imem_addr_o,
    input  logic               imem_gnt_i,
    input  logic               imem_rvalid_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    input  logic               redirect_i,
    input  logic [XLEN-1:0]    redirect_pc_i,
    output logic               instr_valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [XLEN-1:0]    instr_pc_o,
    input  logic               instr_ready_i,
    output logic [31:0]        perf_fetch_cnt_o,
    output logic [31:0]        perf_drop_cnt_o
);

    localparam int               CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    fetch_state_e     state;
    logic             req_q;
    logic [XLEN-1:0]  tag_pc;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] count_after_push;
    logic             room_after_push;
    fetch_entry_t     fifo_in;
    fetch_entry_t     fifo_head;

    assign fifo_push        = (state == WAIT) && imem_rvalid_i && !redirect_i;
    assign fifo_pop         = instr_ready_i && !fifo_empty && !redirect_i;
    assign count_after_push = fifo_count + ONE_C - CNT_W'(fifo_pop);
    assign room_after_push  = (count_after_push < DEPTH_C);
    assign fifo_in          = '{instr: ILEN'(imem_rdata_i), pc: tag_pc};

    assign imem_req_o    = req_q;
    assign imem_addr_o   = pc_i;
    assign instr_valid_o = !fifo_empty;
    assign instr_o       = fifo_empty ? '0 : INSTR_W'(fifo_head.instr);
    assign instr_pc_o    = fifo_empty ? '0 : fifo_head.pc;

    // A redirect outranks a grant, so a coincident grant never advances the PC by a step.
    always_comb begin
        pc_ready_o = 1'b0;
        pc_next_o  = '0;
        if (!reset_i) begin
            if (redirect_i) begin
                pc_ready_o = 1'b1;
                pc_next_o  = redirect_pc_i & ~XLEN'(3);
            end else if ((state == REQ) && imem_gnt_i) begin
                pc_ready_o = 1'b1;
                pc_next_o  = pc_i + XLEN'(PC_STEP);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state  <= IDLE;
            req_q  <= 1'b0;
            tag_pc <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (redirect_i || !fifo_full) begin
                        state <= REQ;
                        req_q <= 1'b1;
                    end
                end
                REQ: begin
                    // Without a grant the request simply re-presents at the redirected pc_i.
                    if (imem_gnt_i) begin
                        state  <= redirect_i ? DROP : WAIT;
                        req_q  <= 1'b0;
                        tag_pc <= pc_i;
                    end
                end
                WAIT: begin
                    if (redirect_i) begin
                        if (imem_rvalid_i) begin
                            state <= REQ;
                            req_q <= 1'b1;
                        end else begin
                            state <= DROP;
                        end
                    end else if (imem_rvalid_i) begin
                        if (room_after_push) begin
                            state <= REQ;
                            req_q <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DROP: begin
                    if (imem_rvalid_i) begin
                        state <= REQ;
                        req_q <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (fifo_push),
        .entry_i (fifo_in),
        .pop_i   (fifo_pop),
        .flush_i (redirect_i),
        .head_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef FETCH_PERF_EN
    logic        discard;
    logic [32:0] drop_sum;
    logic [31:0] fetch_cnt;
    logic [31:0] drop_cnt;

    // Drops count both squashed responses and buffered entries thrown away by a flush.
    assign discard  = imem_rvalid_i && ((state == DROP) || ((state == WAIT) && redirect_i));
    assign drop_sum = {1'b0, drop_cnt} + 33'(discard) + (redirect_i ? 33'(fifo_count) : 33'd0);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fetch_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (fifo_push && (fetch_cnt != '1)) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            drop_cnt <= drop_sum[32] ? '1 : drop_sum[31:0];
        end
    end

    assign perf_fetch_cnt_o = fetch_cnt;
    assign perf_drop_cnt_o  = drop_cnt;
`else
    assign perf_fetch_cnt_o = '0;
    assign perf_drop_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized traffic against a queue-level model.
module tb_fetch_ctrl;

    localparam int DEPTH = 2;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic [63:0] pc_i = '0;
    logic [63:0] pc_next_o;
    logic        pc_ready_o;
    logic        imem_req_o;
    logic [63:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        redirect_i = 1'b0;
    logic [63:0] redirect_pc_i = '0;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [63:0] instr_pc_o;
    logic        instr_ready_i = 1'b0;
    logic [31:0] perf_fetch_cnt_o;
    logic [31:0] perf_drop_cnt_o;

    fetch_ctrl #(.FIFO_DEPTH(DEPTH), .INSTR_W(32)) dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .pc_i             (pc_i),
        .pc_next_o        (pc_next_o),
        .pc_ready_o       (pc_ready_o),
        .imem_req_o       (imem_req_o),
        .imem_addr_o      (imem_addr_o),
        .imem_gnt_i       (imem_gnt_i),
        .imem_rvalid_i    (imem_rvalid_i),
        .imem_rdata_i     (imem_rdata_i),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .instr_valid_o    (instr_valid_o),
        .instr_o          (instr_o),
        .instr_pc_o       (instr_pc_o),
        .instr_ready_i    (instr_ready_i),
        .perf_fetch_cnt_o (perf_fetch_cnt_o),
        .perf_drop_cnt_o  (perf_drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // stimulus knobs
    int unsigned gnt_pct = 0, rdy_pct = 0, redir_pct = 0, resp_delay = 1;
    bit          use_fixed = 1'b1;
    logic [31:0] fixed_data = 32'h0000_0013;
    bit          redir_once = 1'b0;
    logic [63:0] redir_tgt = '0;

    // memory responder
    bit resp_active = 1'b0;
    int resp_cnt = 0;

    // reference model: buffered entries and the single outstanding fetch
    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
    } ent_t;
    ent_t        q[$];
    bit          outst = 1'b0, squash = 1'b0;
    logic [63:0] tag = '0;
    logic [31:0] exp_fetch = '0, exp_drop = '0;
    int          stall = 0;
    bit          prev_hold = 1'b0;
    logic [63:0] grant_addr[$], grant_next[$], pop_pc[$];
    logic [63:0] pc_nxt_tb = '0;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input int unsigned b);
        logic [32:0] s;
        s = {1'b0, a} + 33'(b);
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    task automatic check_model();
        bit grant, pop;
        if (reset_i) begin
            q.delete();
            outst = 1'b0;
            squash = 1'b0;
            exp_fetch = '0;
            exp_drop = '0;
            stall = 0;
            prev_hold = 1'b0;
            pc_nxt_tb = '0;
            return;
        end
        grant = imem_req_o && imem_gnt_i;

        if (redirect_i) begin
            chk("pc_ready_redir", pc_ready_o, 1);
            chk("pc_next_redir", pc_next_o, redirect_pc_i & ~64'h3);
        end else if (grant) begin
            chk("pc_ready_gnt", pc_ready_o, 1);
            chk("pc_next_gnt", pc_next_o, pc_i + 64'd4);
        end else begin
            chk("pc_ready_quiet", pc_ready_o, 0);
        end
        if (imem_req_o) begin
            chk("req_addr", imem_addr_o, pc_i);
            chk("req_space", (q.size() < DEPTH) && !outst, 1);
        end
        if (prev_hold) chk("req_hold", imem_req_o, 1);
        prev_hold = imem_req_o && !imem_gnt_i && !redirect_i;
        if (!outst && (q.size() < DEPTH) && !imem_req_o) stall++;
        else stall = 0;
        if (stall > 3) begin
            chk("req_stall", imem_req_o, 1);
            stall = 0;
        end
        chk("instr_valid", instr_valid_o, q.size() != 0);
        if (q.size() != 0) begin
            chk("instr", instr_o, q[0].instr);
            chk("instr_pc", instr_pc_o, q[0].pc);
        end
`ifdef FETCH_PERF_EN
        chk("perf_fetch", perf_fetch_cnt_o, exp_fetch);
        chk("perf_drop", perf_drop_cnt_o, exp_drop);
`endif

        pop = (q.size() != 0) && instr_ready_i;
        if (redirect_i) begin
            exp_drop = sat_add(exp_drop, q.size());
            q.delete();
        end else if (pop) begin
            pop_pc.push_back(q[0].pc);
            void'(q.pop_front());
        end
        if (imem_rvalid_i && outst) begin
            if (squash || redirect_i) begin
                exp_drop = sat_add(exp_drop, 1);
            end else begin
                q.push_back('{imem_rdata_i, tag});
                exp_fetch = sat_add(exp_fetch, 1);
            end
            outst = 1'b0;
        end else if (redirect_i && outst) begin
            squash = 1'b1;
        end
        if (grant) begin
            outst = 1'b1;
            tag = pc_i;
            squash = redirect_i;
            grant_addr.push_back(imem_addr_o);
            grant_next.push_back(pc_next_o);
            resp_active = 1'b1;
            resp_cnt = (resp_delay != 0) ? int'(resp_delay) : int'($urandom_range(3, 1));
        end
        pc_nxt_tb = pc_ready_o ? pc_next_o : pc_i;
    endtask

    task automatic cycle();
        imem_gnt_i    = ($urandom_range(99) < gnt_pct);
        instr_ready_i = ($urandom_range(99) < rdy_pct);
        redirect_i    = redir_once || ($urandom_range(99) < redir_pct);
        redirect_pc_i = redir_once ? redir_tgt : {$urandom, $urandom};
        redir_once    = 1'b0;
        imem_rdata_i  = use_fixed ? fixed_data : $urandom;
        imem_rvalid_i = 1'b0;
        if (resp_active) begin
            resp_cnt--;
            if (resp_cnt <= 0) begin
                imem_rvalid_i = 1'b1;
                resp_active = 1'b0;
            end
        end
        @(negedge clk_i);
        check_model();
        @(posedge clk_i);
        #1 pc_i = pc_nxt_tb;
    endtask

    task automatic do_reset();
        gnt_pct = 0;
        rdy_pct = 0;
        redir_pct = 0;
        reset_i = 1'b1;
        cycle();
        cycle();
        chk("rst_req", imem_req_o, 0);
        chk("rst_pc_ready", pc_ready_o, 0);
        chk("rst_pc_next", pc_next_o, 0);
        chk("rst_valid", instr_valid_o, 0);
        chk("rst_instr", instr_o, 0);
        chk("rst_instr_pc", instr_pc_o, 0);
        chk("rst_perf_fetch", perf_fetch_cnt_o, 0);
        chk("rst_perf_drop", perf_drop_cnt_o, 0);
        reset_i = 1'b0;
        grant_addr.delete();
        grant_next.delete();
        pop_pc.delete();
    endtask

    task automatic wait_req(input int max_cycles);
        int n = 0;
        while (!imem_req_o && n < max_cycles) begin
            cycle();
            n++;
        end
        chk("wait_req", imem_req_o, 1);
    endtask

    initial begin
        int req_cnt;
        int n0;

        // sequential fetch with gnt tied high, response one cycle later
        do_reset();
        use_fixed = 1'b1;
        fixed_data = 32'h0000_0013;
        resp_delay = 1;
        gnt_pct = 100;
        rdy_pct = 100;
        repeat (14) cycle();
        for (int i = 0; i < 3; i++) begin
            chk("seq_addr", (grant_addr.size() > i) ? grant_addr[i] : 64'hx, 64'(4 * i));
            chk("seq_next", (grant_next.size() > i) ? grant_next[i] : 64'hx, 64'(4 * (i + 1)));
            chk("seq_pop_pc", (pop_pc.size() > i) ? pop_pc[i] : 64'hx, 64'(4 * i));
        end

        // buffer fills with decode stalled, then one pop admits exactly one refetch
        do_reset();
        gnt_pct = 100;
        rdy_pct = 0;
        repeat (12) cycle();
        req_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (imem_req_o) req_cnt++;
        end
        chk("full_no_req", req_cnt, 0);
        chk("full_head_pc", instr_pc_o, 64'h0);
        n0 = grant_addr.size();
        rdy_pct = 100;
        cycle();
        rdy_pct = 0;
        chk("pop_head_pc", instr_pc_o, 64'h4);
        repeat (8) cycle();
        chk("refill_grants", grant_addr.size() - n0, 1);
        chk("refill_addr", grant_addr[grant_addr.size() - 1], 64'h8);

        // redirect while waiting: late response discarded, refetch at aligned target
        do_reset();
        fixed_data = 32'hDEAD_BEEF;
        resp_delay = 2;
        rdy_pct = 100;
        wait_req(5);
        gnt_pct = 100;
        cycle();
        gnt_pct = 0;
        redir_once = 1'b1;
        redir_tgt = 64'h1002;
        cycle();
        chk("wait_redir_pc", pc_i, 64'h1000);
        chk("wait_redir_empty", instr_valid_o, 0);
        cycle();
        chk("drop_empty", instr_valid_o, 0);
        gnt_pct = 100;
        n0 = grant_addr.size();
        cycle();
        chk("drop_refetch_cnt", grant_addr.size() - n0, 1);
        chk("drop_refetch_addr", grant_addr[grant_addr.size() - 1], 64'h1000);
        gnt_pct = 0;
        repeat (3) cycle();

        // redirect coincident with a grant at 0x40
        do_reset();
        resp_delay = 1;
        fixed_data = 32'h0000_0013;
        redir_once = 1'b1;
        redir_tgt = 64'h40;
        cycle();
        chk("pre_pc", pc_i, 64'h40);
        wait_req(4);
        gnt_pct = 100;
        redir_once = 1'b1;
        redir_tgt = 64'h2000;
        cycle();
        chk("gnt_redir_pc", pc_i, 64'h2000);
        gnt_pct = 0;
        cycle();
        chk("gnt_redir_drop", instr_valid_o, 0);
        gnt_pct = 100;
        n0 = grant_addr.size();
        cycle();
        chk("gnt_redir_addr", (grant_addr.size() > n0) ? grant_addr[n0] : 64'hx, 64'h2000);
        repeat (3) cycle();

        // PC wraps modulo 2^64
        do_reset();
        redir_once = 1'b1;
        redir_tgt = 64'hFFFF_FFFF_FFFF_FFFC;
        cycle();
        gnt_pct = 100;
        rdy_pct = 100;
        repeat (2) cycle();
        chk("wrap_addr", (grant_addr.size() > 0) ? grant_addr[0] : 64'hx, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_next", (grant_next.size() > 0) ? grant_next[0] : 64'hx, 64'h0);
        repeat (4) cycle();

        // reset while waiting; response lands during (d=1) or after (d=2) reset
        for (int d = 1; d <= 2; d++) begin
            do_reset();
            resp_delay = 1;
            gnt_pct = 100;
            rdy_pct = 50;
            repeat (8) cycle();
            gnt_pct = 0;
            wait_req(4);
            resp_delay = d;
            gnt_pct = 100;
            cycle();
            gnt_pct = 0;
            reset_i = 1'b1;
            cycle();
            reset_i = 1'b0;
            chk("midrst_perf_fetch", perf_fetch_cnt_o, 0);
            chk("midrst_perf_drop", perf_drop_cnt_o, 0);
            chk("midrst_req", imem_req_o, 0);
            for (int i = 0; i < 4; i++) begin
                cycle();
                chk("midrst_no_push", instr_valid_o, 0);
            end
        end

        // randomized traffic with occasional resets
        do_reset();
        use_fixed = 1'b0;
        resp_delay = 0;
        gnt_pct = 60;
        rdy_pct = 50;
        redir_pct = 4;
        for (int i = 0; i < 3000; i++) begin
            reset_i = ($urandom_range(299) == 0);
            cycle();
        end
        reset_i = 1'b0;
        redir_pct = 0;
        repeat (6) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
